// File: rtl/pzcorebus_response_burst_scheduler.sv
// Weighted round-robin burst scheduler for a shared corebus response path.
// Holds a registered one-hot grant per burst and chains bursts without bubbles.
module pzcorebus_response_burst_scheduler #(
    parameter int REQUESTS     = 2,
    parameter int WEIGHT_WIDTH = 2,
    parameter int INDEX_WIDTH  = $clog2(REQUESTS)
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic [REQUESTS*WEIGHT_WIDTH-1:0] i_weight,
    input  logic [REQUESTS-1:0]              i_request,
    input  logic [REQUESTS-1:0]              i_last,
    input  logic                             i_ack,
    output logic [REQUESTS-1:0]              o_grant,
    output logic [INDEX_WIDTH-1:0]           o_grant_index,
    output logic                             o_busy
);
    typedef enum logic {IDLE, LOCKED} state_e;

    state_e                  state_q, state_d;
    logic [REQUESTS-1:0]     grant_q, grant_d;
    logic [INDEX_WIDTH-1:0]  grant_index_q, grant_index_d;
    logic [INDEX_WIDTH-1:0]  pointer_q, pointer_d;
    logic [INDEX_WIDTH-1:0]  last_q, last_d;
    logic [WEIGHT_WIDTH-1:0] credit_q, credit_d;

    logic [WEIGHT_WIDTH-1:0] weight [REQUESTS];
    logic [REQUESTS-1:0]     arb_request;
    logic                    free;
    logic                    arbitrate;
    logic                    regrant;
    logic                    hi_found, lo_found, rr_found;
    logic [INDEX_WIDTH-1:0]  hi_index, lo_index, rr_index;

    function automatic logic [WEIGHT_WIDTH-1:0] credit_after_free(input logic [WEIGHT_WIDTH-1:0] c);
        return (c == '0) ? '0 : c - WEIGHT_WIDTH'(1);
    endfunction

    function automatic logic [WEIGHT_WIDTH-1:0] credit_load(input logic [WEIGHT_WIDTH-1:0] w);
        return (w == '0) ? WEIGHT_WIDTH'(1) : w;
    endfunction

    always_comb begin
        for (int k = 0; k < REQUESTS; k++) begin
            weight[k] = i_weight[k*WEIGHT_WIDTH +: WEIGHT_WIDTH];
        end
    end

    // The beat being consumed on free still shows its request; mask it so the
    // finishing source cannot win the back-to-back slot.
    assign free      = (state_q == LOCKED) && i_ack && i_last[grant_index_q];
    assign arbitrate = ((state_q == IDLE) && (|i_request)) || free;
    assign regrant   = (state_q == IDLE) && (credit_q != '0) && i_request[last_q];

    always_comb begin
        arb_request = i_request;
        if (free) begin
            arb_request[grant_index_q] = 1'b0;
        end
    end

    // Search order pointer+1 .. REQUESTS-1, then 0 .. pointer; lowest index wins in each region.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_index = '0;
        lo_index = '0;
        for (int k = REQUESTS - 1; k >= 0; k--) begin
            if (arb_request[k]) begin
                if (k > int'(pointer_q)) begin
                    hi_found = 1'b1;
                    hi_index = INDEX_WIDTH'(k);
                end else begin
                    lo_found = 1'b1;
                    lo_index = INDEX_WIDTH'(k);
                end
            end
        end
        rr_found = hi_found || lo_found;
        rr_index = hi_found ? hi_index : lo_index;
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        grant_index_d = grant_index_q;
        pointer_d     = pointer_q;
        last_d        = last_q;
        credit_d      = credit_q;

        if (free) begin
            credit_d = credit_after_free(credit_q);
        end

        if (arbitrate) begin
            if (regrant) begin
                state_d          = LOCKED;
                grant_d          = '0;
                grant_d[last_q]  = 1'b1;
                grant_index_d    = last_q;
            end else if (rr_found) begin
                state_d           = LOCKED;
                grant_d           = '0;
                grant_d[rr_index] = 1'b1;
                grant_index_d     = rr_index;
                pointer_d         = rr_index;
                last_d            = rr_index;
                credit_d          = credit_load(weight[rr_index]);
            end else begin
                state_d       = IDLE;
                grant_d       = '0;
                grant_index_d = '0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            grant_index_q <= '0;
            pointer_q     <= INDEX_WIDTH'(REQUESTS - 1);
            last_q        <= '0;
            credit_q      <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_index_q <= grant_index_d;
            pointer_q     <= pointer_d;
            last_q        <= last_d;
            credit_q      <= credit_d;
        end
    end

    assign o_grant       = grant_q;
    assign o_grant_index = grant_index_q;
    assign o_busy        = (state_q == LOCKED);

    // A locked source must keep its beat valid until the burst's last beat is accepted.
    grant_request_held: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (state_q == LOCKED) |-> i_request[grant_index_q]);

    grant_onehot0: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        $onehot0(grant_q));

endmodule
